// File: rtl/sample_scheduler.sv
// Round-robin burst scheduler for a shared sampler.
// Each granted channel gets SP_NUM sample strobes; the gap before sample k+1
// grows by one cycle per sample (DELAY_TIME + k idle cycles after sample k).
module sample_scheduler #(
  parameter int N_CH       = 4,
  parameter int SP_NUM     = 6,
  parameter int DELAY_TIME = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            abort,
  output logic [N_CH-1:0] grant,
  output logic            sp_en,
  output logic [2:0]      sp_ch,
  output logic [7:0]      sp_idx,
  output logic            busy,
  output logic [N_CH-1:0] done
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SAMPLE, S_GAP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [2:0]      rr_q, rr_d;
  logic [2:0]      ch_q, ch_d;
  logic [7:0]      k_q, k_d;
  logic [8:0]      gap_q, gap_d;

  logic [7:0]      pend8;
  logic [3:0]      cand;
  logic            win_found;
  logic [2:0]      win_ch;
  logic [N_CH-1:0] ch_oh;
  logic [2:0]      rr_next;
  logic [8:0]      gap_last;

  assign pend8    = 8'(pending_q);
  assign ch_oh    = {{(N_CH-1){1'b0}}, 1'b1} << ch_q;
  assign rr_next  = (ch_q == 3'(N_CH-1)) ? 3'd0 : ch_q + 3'd1;
  // Last gap-counter value before the next sample; 9 bits so it never wraps.
  assign gap_last = 9'(DELAY_TIME) + {1'b0, k_q} - 9'd1;

  assign busy   = (state_q != S_IDLE);
  assign sp_ch  = ch_q;
  assign sp_idx = k_q;

  // Round-robin pick: first pending channel at or after rr_q, wrapping.
  always_comb begin
    cand      = '0;
    win_found = 1'b0;
    win_ch    = rr_q;
    for (int i = 0; i < N_CH; i++) begin
      cand = {1'b0, rr_q} + 4'(i);
      if (cand >= 4'(N_CH)) cand = cand - 4'(N_CH);
      if (!win_found && pend8[cand[2:0]]) begin
        win_found = 1'b1;
        win_ch    = cand[2:0];
      end
    end
  end

  // Next-state and strobe outputs; a new request wins over the grant clear.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ch_d    = ch_q;
    k_d     = k_q;
    gap_d   = gap_q;
    grant   = '0;
    sp_en   = 1'b0;
    done    = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          ch_d    = win_ch;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        grant = ch_oh;
        k_d   = '0;
        if (abort) begin
          state_d = S_IDLE;
          rr_d    = rr_next;
        end else begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
          rr_d    = rr_next;
        end else begin
          sp_en = 1'b1;
          if (k_q == 8'(SP_NUM-1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          rr_d    = rr_next;
        end else if (gap_q == gap_last) begin
          state_d = S_SAMPLE;
          k_d     = k_q + 8'd1;
        end else begin
          gap_d = gap_q + 9'd1;
        end
      end
      S_DONE: begin
        done    = ch_oh;
        rr_d    = rr_next;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    pending_d = (pending_q & ~grant) | req;
  end

  // State registers; reset drops the burst and any pending requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      rr_q      <= '0;
      ch_q      <= '0;
      k_q       <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      ch_q      <= ch_d;
      k_q       <= k_d;
      gap_q     <= gap_d;
    end
  end

endmodule

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of requesting channels (2..8).
REQ-002 SHALL have parameter SP_NUM, default 6, samples per burst (1..255).
REQ-003 SHALL have parameter DELAY_TIME, default 200, base inter-sample gap in clk cycles (1..255; 1 us at 200 MHz).
REQ-004 SHALL have port clk  input  1  system clock, 200 MHz; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  N_CH  per-channel single-cycle trigger request pulses.
REQ-007 SHALL have port abort  input  1  terminates the active burst.
REQ-008 SHALL have port grant  output  N_CH  one-hot, one-cycle pulse when a channel's burst starts.
REQ-009 SHALL have port sp_en  output  1  sample strobe to the shared sampler, one cycle per sample.
REQ-010 SHALL have port sp_ch  output  3  channel index of the active burst, valid while busy.
REQ-011 SHALL have port sp_idx  output  8  index k of the current sample, 0..SP_NUM-1, valid with sp_en.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  N_CH  one-cycle pulse on the channel whose burst completed normally.

Function
REQ-014 SHALL keep pending[N_CH]: bit i set in any cycle req[i]=1; cleared on the cycle grant[i]=1 unless req[i]=1 that same cycle (set wins).
REQ-015 SHALL implement states IDLE, GRANT, SAMPLE, GAP, DONE; exactly one active per cycle.
REQ-016 IDLE: if any pending bit set, SHALL select winner c by round-robin starting at rr_ptr, latch c into sp_ch, go to GRANT; otherwise stay.
REQ-017 GRANT: grant[c]=1 for this cycle only; k cleared to 0; next state SAMPLE.
REQ-018 SAMPLE: sp_en=1, sp_idx=k; if k==SP_NUM-1 next state DONE, else next state GAP with gap counter cleared.
REQ-019 GAP: SHALL stay exactly DELAY_TIME+k cycles, then go to SAMPLE with k incremented; sample k+1 occurs DELAY_TIME+k+1 cycles after sample k.
REQ-020 Gap counter SHALL be 9 bits wide so DELAY_TIME+SP_NUM-1 (max 509) never wraps.
REQ-021 DONE: done[c]=1 for this cycle only; rr_ptr <= (c+1) mod N_CH; next state IDLE.
REQ-022 Grant-to-first-sample latency SHALL be 1 cycle; request-to-grant latency from IDLE SHALL be 2 cycles (req registered into pending, then IDLE decision).
REQ-023 Requests arriving while busy SHALL be held in pending and served by round-robin after the current burst; none are lost.
REQ-024 abort=1 in GRANT, SAMPLE or GAP SHALL force next state IDLE; no done pulse; rr_ptr <= (c+1) mod N_CH; sp_en is suppressed in that cycle.
REQ-025 abort in IDLE or DONE SHALL be ignored; DONE completes normally.
REQ-026 SP_NUM=1 SHALL produce GRANT, SAMPLE, DONE with no GAP state.
REQ-027 grant, done, sp_en SHALL never be asserted together.

Reset
REQ-028 On rst=1 SHALL go to IDLE and clear pending, rr_ptr, k, and gap counter; grant=0, done=0, sp_en=0, sp_ch=0, sp_idx=0, busy=0 in the following cycle.
REQ-029 rst mid-burst SHALL abandon the burst with no done pulse; requests during reset are discarded.

Verification (N_CH=4, SP_NUM=3, DELAY_TIME=4)
REQ-030 req[1] pulse at cycle 0 -> grant[1] at cycle 2; sp_en at 3, 8, 14 with sp_idx 0,1,2; done[1] at 15; busy low at 16.
REQ-031 req=4'b1111 in one cycle, rr_ptr=0 -> bursts in order ch0, ch1, ch2, ch3, each with full done; none dropped.
REQ-032 req[2] pulses during ch0's burst and again after -> single ch2 burst served once after ch0 done.
REQ-033 abort asserted in GAP after sample 1 of ch3 -> no further sp_en, no done[3], IDLE next cycle, next grant chooses ch0 first.
REQ-034 SP_NUM=1 build, req[0] -> grant, one sp_en with sp_idx=0, done[0] on consecutive cycles.
REQ-035 rst asserted during SAMPLE of ch1 with req[2] pending -> all outputs 0 next cycle; pending cleared; no grant until a new req.
